// File: rtl/stage_ex_pkg.sv
// Shared types and constants for the execute stage: ALU/md opcodes, md FSM states,
// the ID/EX bundle and the ALU evaluation helper.
package ex_pkg;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_LUI   = 4'd11;
  localparam logic [3:0] ALU_PASSA = 4'd12;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIVU  = 3'd2;
  localparam logic [2:0] MD_MFHI  = 3'd3;
  localparam logic [2:0] MD_MFLO  = 3'd4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic        dmem_ena;
    logic        dmem_wena;
    logic [1:0]  dmem_type;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rd_waddr;
    logic        rd_sel;
    logic        rd_wena;
    logic [31:0] immed;
    logic [31:0] shamt;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [3:0]  alu_sel;
    logic [2:0]  md_op;
  } ex_in_t;

  // Any op that touches HI/LO or the md unit must wait while the md unit is busy.
  function automatic logic is_md_dep(input logic [2:0] op);
    return (op >= MD_MULTU) && (op <= MD_MFLO);
  endfunction

  function automatic logic [31:0] alu_eval(input logic [3:0] sel, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (sel)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_NOR:   r = ~(a | b);
      ALU_SLT:   r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  r = {31'd0, a < b};
      ALU_SLL:   r = b << a[4:0];
      ALU_SRL:   r = b >> a[4:0];
      ALU_SRA:   r = $unsigned($signed(b) >>> a[4:0]);
      ALU_LUI:   r = {b[15:0], 16'h0000};
      ALU_PASSA: r = a;
      default:   r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/stage_ex_if.sv
// ID/EX input bundle and EX/MEM output bundle of the execute stage.
interface stage_ex_if;
  logic        dmem_ena_i, dmem_wena_i;
  logic [1:0]  dmem_type_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic [4:0]  rd_waddr_i;
  logic        rd_sel_i, rd_wena_i;
  logic [31:0] immed_i, shamt_i;
  logic        alu_a_sel_i, alu_b_sel_i;
  logic [3:0]  alu_sel_i;
  logic [2:0]  md_op_i;
  logic        stall_o;
  logic        dmem_ena_o, dmem_wena_o;
  logic [1:0]  dmem_type_o;
  logic [31:0] alu_result_o, store_data_o;
  logic [4:0]  rd_waddr_o;
  logic        rd_sel_o, rd_wena_o;

  modport slave (
    input  dmem_ena_i, dmem_wena_i, dmem_type_i, rs_data_i, rt_data_i, rd_waddr_i,
           rd_sel_i, rd_wena_i, immed_i, shamt_i, alu_a_sel_i, alu_b_sel_i,
           alu_sel_i, md_op_i,
    output stall_o, dmem_ena_o, dmem_wena_o, dmem_type_o, alu_result_o,
           store_data_o, rd_waddr_o, rd_sel_o, rd_wena_o
  );

  modport master (
    output dmem_ena_i, dmem_wena_i, dmem_type_i, rs_data_i, rt_data_i, rd_waddr_i,
           rd_sel_i, rd_wena_i, immed_i, shamt_i, alu_a_sel_i, alu_b_sel_i,
           alu_sel_i, md_op_i,
    input  stall_o, dmem_ena_o, dmem_wena_o, dmem_type_o, alu_result_o,
           store_data_o, rd_waddr_o, rd_sel_o, rd_wena_o
  );
endinterface

// File: rtl/stage_ex_md_unit.sv
// Iterative unsigned multiply (shift-add) and restoring divide sharing one
// accumulator pair; HI/LO update only on the final iteration edge.
module md_unit
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        div_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam int CW = $clog2(MD_CYCLES);

  md_state_e   r_state, w_state_next;
  logic [CW-1:0] r_count;
  logic        r_div;
  logic [31:0] r_acc_hi, r_acc_lo, r_opnd, r_hi, r_lo;
  logic [32:0] w_mul_sum, w_rem_sh, w_trial;
  logic [31:0] w_step_hi, w_step_lo;
  logic        w_last;

  assign w_last = (r_count == CW'(MD_CYCLES - 1));

  // Multiply: acc_hi accumulates partial products, acc_lo shifts the multiplier out.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  always_comb begin
    w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'd0);
    w_rem_sh  = {r_acc_hi, r_acc_lo[31]};
    w_trial   = w_rem_sh - {1'b0, r_opnd};
    if (r_div) begin
      if (!w_trial[32]) begin
        w_step_hi = w_trial[31:0];
        w_step_lo = {r_acc_lo[30:0], 1'b1};
      end else begin
        w_step_hi = w_rem_sh[31:0];
        w_step_lo = {r_acc_lo[30:0], 1'b0};
      end
    end else begin
      w_step_hi = w_mul_sum[32:1];
      w_step_lo = {w_mul_sum[0], r_acc_lo[31:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= MD_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MD_IDLE: if (start_i) w_state_next = MD_BUSY;
      MD_BUSY: if (w_last)  w_state_next = MD_IDLE;
      default: w_state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state == MD_BUSY);
    hi_o   = r_hi;
    lo_o   = r_lo;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_div    <= 1'b0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (r_state == MD_IDLE) begin
      if (start_i) begin
        r_count  <= '0;
        r_div    <= div_i;
        r_acc_hi <= '0;
        r_acc_lo <= a_i;
        r_opnd   <= b_i;
      end
    end else begin
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
      r_count  <= w_last ? '0 : r_count + CW'(1);
      if (w_last) begin
        r_hi <= w_step_hi;
        r_lo <= w_step_lo;
      end
    end
  end
endmodule

// File: rtl/stage_ex.sv
// Execute stage: operand muxes, ALU, HI/LO reads, md unit and a one-entry slot
// that parks an HI/LO-dependent instruction while the md unit is busy.
module stage_ex
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  stage_ex_if.slave ex
);
  ex_in_t      w_in, w_sel, r_pend;
  logic        r_pend_valid;
  logic        w_busy, w_issue, w_dep_in, w_hold, w_md_start, w_md_op;
  logic [31:0] w_hi, w_lo, w_op_a, w_op_b, w_alu;

  always_comb begin
    w_in.dmem_ena  = ex.dmem_ena_i;
    w_in.dmem_wena = ex.dmem_wena_i;
    w_in.dmem_type = ex.dmem_type_i;
    w_in.rs_data   = ex.rs_data_i;
    w_in.rt_data   = ex.rt_data_i;
    w_in.rd_waddr  = ex.rd_waddr_i;
    w_in.rd_sel    = ex.rd_sel_i;
    w_in.rd_wena   = ex.rd_wena_i;
    w_in.immed     = ex.immed_i;
    w_in.shamt     = ex.shamt_i;
    w_in.alu_a_sel = ex.alu_a_sel_i;
    w_in.alu_b_sel = ex.alu_b_sel_i;
    w_in.alu_sel   = ex.alu_sel_i;
    w_in.md_op     = ex.md_op_i;
  end

  // The parked instruction takes the slot of the guaranteed bubble in the issue cycle.
  assign w_issue    = !w_busy && r_pend_valid;
  assign w_sel      = w_issue ? r_pend : w_in;
  assign w_dep_in   = is_md_dep(w_in.md_op);
  assign w_hold     = w_busy && w_dep_in;
  assign w_md_op    = (w_sel.md_op == MD_MULTU) || (w_sel.md_op == MD_DIVU);
  assign w_md_start = !w_busy && w_md_op;
  assign ex.stall_o = w_busy && (r_pend_valid || w_dep_in);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
    end else if (w_hold && !r_pend_valid) begin
      r_pend_valid <= 1'b1;
      r_pend       <= w_in;
    end else if (w_issue) begin
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
    end
  end

  assign w_op_a = w_sel.alu_a_sel ? w_sel.shamt : w_sel.rs_data;
  assign w_op_b = w_sel.alu_b_sel ? w_sel.immed : w_sel.rt_data;
  assign w_alu  = alu_eval(w_sel.alu_sel, w_op_a, w_op_b);

  md_unit #(.MD_CYCLES(MD_CYCLES)) u_md (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_md_start),
    .div_i   (w_sel.md_op == MD_DIVU),
    .a_i     (w_sel.rs_data),
    .b_i     (w_sel.rt_data),
    .busy_o  (w_busy),
    .hi_o    (w_hi),
    .lo_o    (w_lo)
  );

  always_comb begin
    ex.dmem_ena_o   = w_sel.dmem_ena  && !w_md_op;
    ex.dmem_wena_o  = w_sel.dmem_wena && !w_md_op;
    ex.rd_wena_o    = w_sel.rd_wena   && !w_md_op;
    ex.dmem_type_o  = w_sel.dmem_type;
    ex.store_data_o = w_sel.rt_data;
    ex.rd_waddr_o   = w_sel.rd_waddr;
    ex.rd_sel_o     = w_sel.rd_sel;
    case (w_sel.md_op)
      MD_MFHI: ex.alu_result_o = w_hi;
      MD_MFLO: ex.alu_result_o = w_lo;
      default: ex.alu_result_o = w_alu;
    endcase
    if (w_hold) begin
      ex.dmem_ena_o   = 1'b0;
      ex.dmem_wena_o  = 1'b0;
      ex.rd_wena_o    = 1'b0;
      ex.dmem_type_o  = '0;
      ex.store_data_o = '0;
      ex.rd_waddr_o   = '0;
      ex.rd_sel_o     = 1'b0;
      ex.alu_result_o = '0;
    end
  end
endmodule

// File: tb/tb_stage_ex.sv
// Scoreboard bench for stage_ex: driver pushes model expectations, monitor pops
// and compares on the falling edge.
module tb_stage_ex;
  import ex_pkg::*;

  typedef struct packed {
    logic        stall;
    logic        dmem_ena;
    logic        dmem_wena;
    logic [1:0]  dmem_type;
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  waddr;
    logic        rd_sel;
    logic        rd_wena;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stage_ex_if u_if ();

  stage_ex #(.MD_CYCLES(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ex    (u_if)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // Reference model state: an md op accepted in cycle c occupies c+1..c+32 and
  // its HI/LO become visible from c+33.
  ex_in_t      m_slot = '0;
  bit          m_slot_valid = 1'b0;
  int          m_cyc = 0;
  int          m_acc_cyc = 0;
  bit          m_acc_valid = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_hi_new = '0, m_lo_new = '0;
  bit          m_stall_prev = 1'b0;

  function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(a[4:0]);
    case (code)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: return 32'(int'(b) >>> sh);
      4'd11: return {b[15:0], 16'h0000};
      4'd12: return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t ref_out(input ex_in_t x);
    exp_t        e;
    logic [31:0] a, b;
    bit          mdx;
    a = x.alu_a_sel ? x.shamt : x.rs_data;
    b = x.alu_b_sel ? x.immed : x.rt_data;
    mdx = (x.md_op == 3'd1) || (x.md_op == 3'd2);
    e.stall     = 1'b0;
    e.dmem_ena  = mdx ? 1'b0 : x.dmem_ena;
    e.dmem_wena = mdx ? 1'b0 : x.dmem_wena;
    e.rd_wena   = mdx ? 1'b0 : x.rd_wena;
    e.dmem_type = x.dmem_type;
    e.store     = x.rt_data;
    e.waddr     = x.rd_waddr;
    e.rd_sel    = x.rd_sel;
    if (x.md_op == 3'd3)      e.result = m_hi;
    else if (x.md_op == 3'd4) e.result = m_lo;
    else                      e.result = ref_alu(x.alu_sel, a, b);
    return e;
  endfunction

  task automatic model_step(input ex_in_t in, input bit r, output exp_t e);
    bit          busy, issue, dep;
    ex_in_t      x;
    logic [63:0] p;
    if (r) begin
      m_slot_valid = 1'b0;
      m_acc_valid  = 1'b0;
      m_hi = '0;
      m_lo = '0;
    end
    busy = m_acc_valid && (m_cyc > m_acc_cyc) && (m_cyc <= m_acc_cyc + 32);
    if (m_acc_valid && m_cyc >= m_acc_cyc + 33) begin
      m_hi = m_hi_new;
      m_lo = m_lo_new;
      m_acc_valid = 1'b0;
    end
    issue = !busy && m_slot_valid;
    x = issue ? m_slot : in;
    dep = (in.md_op >= 3'd1) && (in.md_op <= 3'd4);
    if (busy && dep) begin
      e = '0;
      e.stall = 1'b1;
      if (!m_slot_valid) begin
        m_slot = in;
        m_slot_valid = 1'b1;
      end
    end else begin
      e = ref_out(x);
      e.stall = busy && m_slot_valid;
      if (issue) m_slot_valid = 1'b0;
      if (!r && !busy && (x.md_op == 3'd1 || x.md_op == 3'd2)) begin
        m_acc_valid = 1'b1;
        m_acc_cyc = m_cyc;
        if (x.md_op == 3'd1) begin
          p = {32'd0, x.rs_data} * {32'd0, x.rt_data};
          m_hi_new = p[63:32];
          m_lo_new = p[31:0];
        end else if (x.rt_data == 32'd0) begin
          m_lo_new = 32'hFFFF_FFFF;
          m_hi_new = x.rs_data;
        end else begin
          m_lo_new = x.rs_data / x.rt_data;
          m_hi_new = x.rs_data % x.rt_data;
        end
      end
    end
    m_stall_prev = e.stall;
    m_cyc++;
  endtask

  task automatic apply(input ex_in_t x);
    u_if.dmem_ena_i  = x.dmem_ena;
    u_if.dmem_wena_i = x.dmem_wena;
    u_if.dmem_type_i = x.dmem_type;
    u_if.rs_data_i   = x.rs_data;
    u_if.rt_data_i   = x.rt_data;
    u_if.rd_waddr_i  = x.rd_waddr;
    u_if.rd_sel_i    = x.rd_sel;
    u_if.rd_wena_i   = x.rd_wena;
    u_if.immed_i     = x.immed;
    u_if.shamt_i     = x.shamt;
    u_if.alu_a_sel_i = x.alu_a_sel;
    u_if.alu_b_sel_i = x.alu_b_sel;
    u_if.alu_sel_i   = x.alu_sel;
    u_if.md_op_i     = x.md_op;
  endtask

  task automatic drive(input ex_in_t x, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    apply(x);
    model_step(x, r, e);
    exp_q.push_back(e);
  endtask

  // Honour stall: while the stage stalls, ID/EX delivers bubbles.
  task automatic send(input ex_in_t x);
    ex_in_t bub;
    int     guard;
    bub = '0;
    guard = 0;
    while (m_stall_prev) begin
      drive(bub, 1'b0);
      guard++;
      if (guard > 100) begin
        $display("FAIL stall_bound: stall held %0d cycles, required <= 100", guard);
        $fatal(1, "stall bound exceeded");
      end
    end
    drive(x, 1'b0);
  endtask

  function automatic ex_in_t mk(input logic [3:0] alu, input logic [2:0] md,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] imm, input logic [31:0] sh,
                                input logic asel, input logic bsel);
    ex_in_t x;
    x = '0;
    x.alu_sel = alu;
    x.md_op = md;
    x.rs_data = rs;
    x.rt_data = rt;
    x.immed = imm;
    x.shamt = sh;
    x.alu_a_sel = asel;
    x.alu_b_sel = bsel;
    x.rd_waddr = 5'd9;
    x.rd_wena = 1'b1;
    x.dmem_type = 2'd2;
    return x;
  endfunction

  function automatic ex_in_t rand_instr();
    ex_in_t      x;
    int unsigned r;
    r = $urandom_range(0, 99);
    x.dmem_ena  = 1'($urandom);
    x.dmem_wena = 1'($urandom);
    x.dmem_type = 2'($urandom);
    x.rs_data   = $urandom;
    x.rt_data   = $urandom;
    x.rd_waddr  = 5'($urandom);
    x.rd_sel    = 1'($urandom);
    x.rd_wena   = 1'($urandom);
    x.immed     = $urandom;
    x.shamt     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
    x.alu_a_sel = 1'($urandom);
    x.alu_b_sel = 1'($urandom);
    x.alu_sel   = 4'($urandom);
    if (r < 8) x.md_op = 3'd1;
    else if (r < 16) begin
      x.md_op = 3'd2;
      case ($urandom_range(0, 3))
        0: x.rt_data = 32'd0;
        1: x.rt_data = 32'($urandom_range(1, 1000));
        default: ;
      endcase
    end
    else if (r < 26) x.md_op = 3'd3;
    else if (r < 36) x.md_op = 3'd4;
    else if (r < 40) x.md_op = 3'($urandom_range(5, 7));
    else x.md_op = 3'd0;
    return x;
  endfunction

  initial begin : monitor
    exp_t e, a, e2, a2;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a.stall     = u_if.stall_o;
        a.dmem_ena  = u_if.dmem_ena_o;
        a.dmem_wena = u_if.dmem_wena_o;
        a.dmem_type = u_if.dmem_type_o;
        a.result    = u_if.alu_result_o;
        a.store     = u_if.store_data_o;
        a.waddr     = u_if.rd_waddr_o;
        a.rd_sel    = u_if.rd_sel_o;
        a.rd_wena   = u_if.rd_wena_o;
        n_checks++;
        if (a.stall !== e.stall) begin
          n_fail++;
          $display("FAIL stall txn %0d: got %b, required %b", n_txn, a.stall, e.stall);
        end
        a2 = a;
        e2 = e;
        a2.stall = 1'b0;
        e2.stall = 1'b0;
        n_checks++;
        if (a2 !== e2) begin
          n_fail++;
          $display("FAIL bundle txn %0d: got result=%h ena=%b%b%b type=%0d store=%h waddr=%0d sel=%b, required result=%h ena=%b%b%b type=%0d store=%h waddr=%0d sel=%b",
                   n_txn, a.result, a.dmem_ena, a.dmem_wena, a.rd_wena, a.dmem_type,
                   a.store, a.waddr, a.rd_sel, e.result, e.dmem_ena, e.dmem_wena,
                   e.rd_wena, e.dmem_type, e.store, e.waddr, e.rd_sel);
        end
        $display("txn %0d t=%0t md_op=%0d alu=%0d stall=%b result=%h",
                 n_txn, $time, u_if.md_op_i, u_if.alu_sel_i, a.stall, a.result);
        n_txn++;
      end
    end
  end

  initial begin : stim
    ex_in_t bub;
    bub = '0;
    apply(bub);
    #1 rst = 1'b1;
    drive(mk(ALU_ADD, MD_NONE, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0), 1'b1);
    drive(bub, 1'b1);

    send(mk(ALU_ADD,  MD_NONE, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1));
    send(mk(ALU_SRA,  MD_NONE, 32'd0, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 1'b0));
    send(mk(ALU_SLT,  MD_NONE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_SLTU, MD_NONE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0));

    send(mk(ALU_ADD, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));

    send(mk(ALU_ADD, MD_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_DIVU, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));

    send(mk(ALU_ADD, MD_MULTU, 32'd12345, 32'd678, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_NONE, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MULTU, 32'd7, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));

    // Reset lands at T+10 of a divide with an MFLO parked behind it.
    send(mk(ALU_ADD, MD_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    repeat (8) drive(bub, 1'b0);
    drive(mk(ALU_XOR, MD_NONE, 32'h0000_00F0, 32'h0000_000F, 32'd0, 32'd0, 1'b0, 1'b0), 1'b1);
    drive(bub, 1'b0);
    send(mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    send(mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));

    repeat (300) send(rand_instr());
    send(bub);
    drive(bub, 1'b0);

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
